// File: rtl/instr_issuer.sv
// issue_fifo: small circular queue holding issuer entries, occupancy kept as a registered level.
// Latency: a pushed entry reaches the head one cycle after the push edge; no write-to-read bypass.
// Backpressure: push_rdy = ~full; a full queue refuses a push even when a pop happens that cycle.
module issue_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 10
) (
   input  logic                   clock,
   input  logic                   Resetn,
   input  logic                   push_vld,
   output logic                   push_rdy,
   input  logic [W-1:0]           push_dat,
   input  logic                   pop_vld,
   output logic [W-1:0]           head_dat,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          push;
   logic          pop;

   assign push_rdy = (level != FULL_LVL);
   assign empty    = (level == '0);
   assign push     = push_vld & push_rdy;
   assign pop      = pop_vld & ~empty;
   assign head_dat = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two; level tracks push/pop balance.
   always_ff @(posedge clock or negedge Resetn) begin
      if (!Resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   // Storage is deliberately left unreset; only the pointers define what is valid.
   always_ff @(posedge clock) begin
      if (push) mem[wr_ptr] <= push_dat;
   end
endmodule

// instr_issuer: queues host instructions and strobes them into the bus processor at T0.
// Latency: w is asserted 1..4 cycles after a push (first T0 with a non-empty queue); Data/Busy registered.
// Backpressure: InReady = ~full; a full queue refuses pushes even on the cycle an entry is issued.
// Build option INSTR_ISSUER_STEP_EN adds a Step input; each Step rising edge permits one issue.
module instr_issuer #(
   parameter int DEPTH = 4,
   parameter int DW    = 4
) (
   input  logic                   Clock,
   input  logic                   Resetn,
   input  logic                   InValid,
   output logic                   InReady,
   input  logic [1:0]             InF,
   input  logic [1:0]             InRx,
   input  logic [1:0]             InRy,
   input  logic [DW-1:0]          InData,
   input  logic [1:0]             Count,
   output logic                   w,
   output logic [1:0]             F,
   output logic [1:0]             Rx,
   output logic [1:0]             Ry,
   output logic [DW-1:0]          Data,
   output logic                   Busy,
   output logic                   Issued,
   output logic                   Abort,
   output logic [$clog2(DEPTH):0] Level
`ifdef INSTR_ISSUER_STEP_EN
   ,
   input  logic                   Step
`endif
);
   typedef struct packed {
      logic [1:0]    f;
      logic [1:0]    rx;
      logic [1:0]    ry;
      logic [DW-1:0] data;
   } entry_t;

   typedef enum logic {IDLE, EXEC} state_t;

   state_t        state;
   state_t        state_nxt;
   entry_t        in_entry;
   entry_t        head;
   logic          empty;
   logic          issue;
   logic          issue_ok;
   logic [DW-1:0] data_hold;
   logic [1:0]    cur_f;
   logic          unused_cur_f;

   assign in_entry = '{f: InF, rx: InRx, ry: InRy, data: InData};

   issue_fifo #(
      .DEPTH (DEPTH),
      .W     ($bits(entry_t))
   ) u_fifo (
      .clock    (Clock),
      .Resetn   (Resetn),
      .push_vld (InValid),
      .push_rdy (InReady),
      .push_dat (in_entry),
      .pop_vld  (issue),
      .head_dat (head),
      .empty    (empty),
      .level    (Level)
   );

`ifdef INSTR_ISSUER_STEP_EN
   logic step_q;
   logic step_arm;

   // Rising edge of Step arms a single issue; the issue itself disarms unless a new edge lands.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         step_q   <= 1'b0;
         step_arm <= 1'b0;
      end else begin
         step_q <= Step;
         if (Step && !step_q) step_arm <= 1'b1;
         else if (issue)      step_arm <= 1'b0;
      end
   end

   assign issue_ok = step_arm;
`else
   assign issue_ok = 1'b1;
`endif

   // Issue decision and abort detection; instruction fields are only driven during the strobe.
   always_comb begin
      state_nxt = state;
      issue     = 1'b0;
      w         = 1'b0;
      Issued    = 1'b0;
      Abort     = 1'b0;
      F         = 2'b00;
      Rx        = 2'b00;
      Ry        = 2'b00;
      case (state)
         IDLE: begin
            if (Count == 2'b00 && !empty && issue_ok) begin
               issue     = 1'b1;
               w         = 1'b1;
               Issued    = 1'b1;
               F         = head.f;
               Rx        = head.rx;
               Ry        = head.ry;
               state_nxt = EXEC;
            end
         end
         EXEC: begin
            // Counter back at T0 mid-instruction means the processor was reset under us.
            if (Count == 2'b00) begin
               Abort     = 1'b1;
               state_nxt = IDLE;
            end else if (Count == 2'b11) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register plus the immediate/opcode of the instruction in flight, captured at issue.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state     <= IDLE;
         data_hold <= '0;
         cur_f     <= 2'b00;
      end else begin
         state <= state_nxt;
         if (issue) begin
            data_hold <= head.data;
            cur_f     <= head.f;
         end
      end
   end

   // Opcode of the in-flight instruction is kept for debug visibility only.
   assign unused_cur_f = ^cur_f;

   assign Data = data_hold;
   assign Busy = (state == EXEC);
endmodule

// File: tb/tb_instr_issuer.sv
// Directed bench for instr_issuer: free-running step counter driven by hand, expected values precomputed.
// Latency: inputs change 1 time unit after each rising edge, outputs sampled 1 unit later.
// Backpressure: exercises full-queue refusal and push/pop on the same edge.
module tb_instr_issuer;
   logic       Clock;
   logic       Resetn;
   logic       InValid;
   logic       InReady;
   logic [1:0] InF;
   logic [1:0] InRx;
   logic [1:0] InRy;
   logic [3:0] InData;
   logic [1:0] Count;
   logic       w;
   logic [1:0] F;
   logic [1:0] Rx;
   logic [1:0] Ry;
   logic [3:0] Data;
   logic       Busy;
   logic       Issued;
   logic       Abort;
   logic [2:0] Level;

   int checks = 0;
   int passes = 0;

   instr_issuer #(.DEPTH(4), .DW(4)) dut (
      .Clock   (Clock),
      .Resetn  (Resetn),
      .InValid (InValid),
      .InReady (InReady),
      .InF     (InF),
      .InRx    (InRx),
      .InRy    (InRy),
      .InData  (InData),
      .Count   (Count),
      .w       (w),
      .F       (F),
      .Rx      (Rx),
      .Ry      (Ry),
      .Data    (Data),
      .Busy    (Busy),
      .Issued  (Issued),
      .Abort   (Abort),
      .Level   (Level)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic drv(input logic v, input logic [1:0] f, input logic [1:0] rx,
                      input logic [1:0] ry, input logic [3:0] d, input logic [1:0] c);
      InValid = v;
      InF     = f;
      InRx    = rx;
      InRy    = ry;
      InData  = d;
      Count   = c;
      #1;
   endtask

   task automatic clk();
      @(posedge Clock);
      #1;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_w"},       w,       1'b0);
      chk({tag, "_F"},       F,       2'b00);
      chk({tag, "_Rx"},      Rx,      2'b00);
      chk({tag, "_Ry"},      Ry,      2'b00);
      chk({tag, "_Data"},    Data,    4'h0);
      chk({tag, "_Busy"},    Busy,    1'b0);
      chk({tag, "_Issued"},  Issued,  1'b0);
      chk({tag, "_Abort"},   Abort,   1'b0);
      chk({tag, "_Level"},   Level,   3'd0);
      chk({tag, "_InReady"}, InReady, 1'b1);
   endtask

   initial begin
      Resetn  = 1'b1;
      InValid = 1'b0;
      InF     = 2'b00;
      InRx    = 2'b00;
      InRy    = 2'b00;
      InData  = 4'h0;
      Count   = 2'b00;
      #1 Resetn = 1'b0;
      #1;
      chk_reset_outputs("rst");
      #10 Resetn = 1'b1;

      // Load R1<-5 then add R1,R1 with the counter free-running.
      drv(1'b1, 2'b00, 2'b01, 2'b00, 4'h5, 2'd2);
      chk("c0_w", w, 1'b0);
      clk(); drv(1'b1, 2'b10, 2'b01, 2'b01, 4'h9, 2'd3);
      chk("c1_level", Level, 3'd1);
      chk("c1_w", w, 1'b0);
      clk(); drv(1'b0, 2'b00, 2'b00, 2'b00, 4'h0, 2'd0);
      chk("c2_w", w, 1'b1);
      chk("c2_issued", Issued, 1'b1);
      chk("c2_F", F, 2'b00);
      chk("c2_Rx", Rx, 2'b01);
      chk("c2_Ry", Ry, 2'b00);
      chk("c2_level", Level, 3'd2);
      chk("c2_busy", Busy, 1'b0);
      clk(); drv(1'b0, 2'b00, 2'b00, 2'b00, 4'h0, 2'd1);
      chk("c3_data", Data, 4'h5);
      chk("c3_busy", Busy, 1'b1);
      chk("c3_level", Level, 3'd1);
      chk("c3_w", w, 1'b0);
      chk("c3_issued", Issued, 1'b0);
      clk(); drv(1'b0, 2'b00, 2'b00, 2'b00, 4'h0, 2'd2);
      chk("c4_issued", Issued, 1'b0);
      clk(); drv(1'b0, 2'b00, 2'b00, 2'b00, 4'h0, 2'd3);
      chk("c5_busy", Busy, 1'b1);
      chk("c5_issued", Issued, 1'b0);
      clk(); drv(1'b0, 2'b00, 2'b00, 2'b00, 4'h0, 2'd0);
      chk("c6_w", w, 1'b1);
      chk("c6_issued", Issued, 1'b1);
      chk("c6_F", F, 2'b10);
      chk("c6_Rx", Rx, 2'b01);
      chk("c6_Ry", Ry, 2'b01);
      chk("c6_busy", Busy, 1'b0);
      chk("c6_level", Level, 3'd1);
      chk("c6_data_held", Data, 4'h5);
      clk(); drv(1'b0, 2'b00, 2'b00, 2'b00, 4'h0, 2'd1);
      chk("c7_data", Data, 4'h9);
      chk("c7_level", Level, 3'd0);
      chk("c7_busy", Busy, 1'b1);
      clk(); drv(1'b0, 2'b00, 2'b00, 2'b00, 4'h0, 2'd2);
      clk(); drv(1'b0, 2'b00, 2'b00, 2'b00, 4'h0, 2'd3);

      // Push into an empty queue in the T0 cycle itself: no bypass, issue waits a full round.
      clk(); drv(1'b1, 2'b01, 2'b10, 2'b11, 4'h3, 2'd0);
      chk("c10_w_nobypass", w, 1'b0);
      chk("c10_busy", Busy, 1'b0);
      chk("c10_level", Level, 3'd0);
      clk(); drv(1'b0, 2'b00, 2'b00, 2'b00, 4'h0, 2'd1);
      chk("c11_level", Level, 3'd1);
      chk("c11_w", w, 1'b0);
      clk(); drv(1'b0, 2'b00, 2'b00, 2'b00, 4'h0, 2'd2);
      clk(); drv(1'b0, 2'b00, 2'b00, 2'b00, 4'h0, 2'd3);
      chk("c13_w", w, 1'b0);
      clk(); drv(1'b0, 2'b00, 2'b00, 2'b00, 4'h0, 2'd0);
      chk("c14_w", w, 1'b1);
      chk("c14_F", F, 2'b01);
      chk("c14_Rx", Rx, 2'b10);
      chk("c14_Ry", Ry, 2'b11);

      // Counter forced back to T0 where T2 was due: abort, then issue at the following T0.
      clk(); drv(1'b1, 2'b11, 2'b00, 2'b01, 4'hA, 2'd1);
      chk("c15_busy", Busy, 1'b1);
      chk("c15_data", Data, 4'h3);
      clk(); drv(1'b1, 2'b00, 2'b11, 2'b00, 4'h7, 2'd0);
      chk("c16_abort", Abort, 1'b1);
      chk("c16_w", w, 1'b0);
      chk("c16_issued", Issued, 1'b0);
      chk("c16_busy", Busy, 1'b1);
      chk("c16_level", Level, 3'd1);
      clk(); drv(1'b0, 2'b00, 2'b00, 2'b00, 4'h0, 2'd1);
      chk("c17_abort", Abort, 1'b0);
      chk("c17_busy", Busy, 1'b0);
      chk("c17_level", Level, 3'd2);
      chk("c17_w", w, 1'b0);
      clk(); drv(1'b0, 2'b00, 2'b00, 2'b00, 4'h0, 2'd2);
      clk(); drv(1'b0, 2'b00, 2'b00, 2'b00, 4'h0, 2'd3);
      chk("c19_w", w, 1'b0);
      clk(); drv(1'b0, 2'b00, 2'b00, 2'b00, 4'h0, 2'd0);
      chk("c20_w", w, 1'b1);
      chk("c20_F", F, 2'b11);
      chk("c20_Rx", Rx, 2'b00);
      chk("c20_Ry", Ry, 2'b01);

      // Fill to DEPTH, hold InValid while full across a pop, then push on a pop cycle.
      clk(); drv(1'b1, 2'b01, 2'b01, 2'b10, 4'h1, 2'd1);
      chk("c21_data", Data, 4'hA);
      chk("c21_level", Level, 3'd1);
      clk(); drv(1'b1, 2'b10, 2'b10, 2'b11, 4'h2, 2'd2);
      chk("c22_level", Level, 3'd2);
      chk("c22_inready", InReady, 1'b1);
      clk(); drv(1'b1, 2'b11, 2'b11, 2'b01, 4'h4, 2'd3);
      chk("c23_level", Level, 3'd3);
      chk("c23_inready", InReady, 1'b1);
      clk(); drv(1'b1, 2'b01, 2'b00, 2'b10, 4'h6, 2'd0);
      chk("c24_level_full", Level, 3'd4);
      chk("c24_inready", InReady, 1'b0);
      chk("c24_w", w, 1'b1);
      chk("c24_F", F, 2'b00);
      chk("c24_Rx", Rx, 2'b11);
      chk("c24_Ry", Ry, 2'b00);
      clk(); drv(1'b0, 2'b00, 2'b00, 2'b00, 4'h0, 2'd1);
      chk("c25_level_nopush_full", Level, 3'd3);
      chk("c25_inready", InReady, 1'b1);
      chk("c25_data", Data, 4'h7);
      clk(); drv(1'b0, 2'b00, 2'b00, 2'b00, 4'h0, 2'd2);
      clk(); drv(1'b0, 2'b00, 2'b00, 2'b00, 4'h0, 2'd3);
      clk(); drv(1'b1, 2'b00, 2'b01, 2'b01, 4'h8, 2'd0);
      chk("c28_w", w, 1'b1);
      chk("c28_F", F, 2'b01);
      chk("c28_Rx", Rx, 2'b01);
      chk("c28_Ry", Ry, 2'b10);
      chk("c28_level", Level, 3'd3);
      clk(); drv(1'b0, 2'b00, 2'b00, 2'b00, 4'h0, 2'd1);
      chk("c29_level_pushpop", Level, 3'd3);
      chk("c29_busy", Busy, 1'b1);
      chk("c29_data", Data, 4'h1);

      // Asynchronous reset in the middle of an instruction with three entries queued.
      Resetn = 1'b0;
      #1;
      chk_reset_outputs("midrst");
      drv(1'b0, 2'b00, 2'b00, 2'b00, 4'h0, 2'd0);
      chk("midrst_t0_w", w, 1'b0);
      clk();
      Resetn = 1'b1;
      drv(1'b0, 2'b00, 2'b00, 2'b00, 4'h0, 2'd1);
      chk("post_c1_w", w, 1'b0);
      clk(); drv(1'b0, 2'b00, 2'b00, 2'b00, 4'h0, 2'd2);
      clk(); drv(1'b0, 2'b00, 2'b00, 2'b00, 4'h0, 2'd3);
      clk(); drv(1'b0, 2'b00, 2'b00, 2'b00, 4'h0, 2'd0);
      chk("post_t0_w", w, 1'b0);
      chk("post_t0_level", Level, 3'd0);
      chk("post_t0_busy", Busy, 1'b0);
      clk(); drv(1'b1, 2'b10, 2'b01, 2'b10, 4'h5, 2'd1);
      chk("post_push_w", w, 1'b0);
      clk(); drv(1'b0, 2'b00, 2'b00, 2'b00, 4'h0, 2'd2);
      chk("post_level", Level, 3'd1);
      clk(); drv(1'b0, 2'b00, 2'b00, 2'b00, 4'h0, 2'd3);
      clk(); drv(1'b0, 2'b00, 2'b00, 2'b00, 4'h0, 2'd0);
      chk("post_issue_w", w, 1'b1);
      chk("post_issue_F", F, 2'b10);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
